instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch stage: owns the program counter, drives the address port of `Instruction_memory` (combinational read, instruction returned in the same cycle), and captures the returned word into the IF/ID pipeline register for decode. It handles hazard stalls, branch/jump redirects from execute, and misaligned-target faults, and keeps a fetch counter for performance monitoring.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: instruction word presented when IF/ID holds no valid instruction.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  fetch address to the instruction memory; equals `pc_q`.
- `imem_instr`  in  32  instruction word from the instruction memory, valid in the same cycle as `imem_addr`.
- `stall`  in  1  hazard unit request: hold PC and IF/ID.
- `flush`  in  1  squash IF/ID contents on the next edge.
- `redirect_valid`  in  1  branch/jump taken in execute.
- `redirect_pc`  in  32  redirect target address.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  32  PC of the IF/ID instruction.
- `if_id_instr`  out  32  IF/ID instruction word.
- `if_id_pc_plus4`  out  32  `if_id_pc + 4`.
- `fetch_fault`  out  1  sticky misaligned-redirect fault.
- `fetch_count`  out  32  number of instructions accepted into IF/ID.

## Operation
- FSM states: BOOT, RUN, FAULT.
- Reset values:
  - `pc_q` = `RESET_PC`
  - `if_id_valid` = 0, `if_id_instr` = `NOP_INSTR`, `if_id_pc` = 0, `if_id_pc_plus4` = 0
  - `fetch_count` = 0, `fetch_fault` = 0
  - state = BOOT
- BOOT: lasts exactly one cycle, then RUN. No fetch is captured. `stall`, `flush` and `redirect_valid` are ignored. `if_id_valid` stays 0.
- RUN, per edge, highest priority first:
  - `redirect_valid` with `redirect_pc[1:0]` != 0:
    - go to FAULT; `fetch_fault` <= 1.
    - `pc_q` holds its value; `if_id_valid` <= 0.
  - `redirect_valid`, aligned target:
    - `pc_q` <= `redirect_pc`.
    - `if_id_valid` <= 0 and `if_id_instr` <= `NOP_INSTR`, whatever `stall` is.
  - `stall`: `pc_q` and all IF/ID fields hold. If `flush` is also 1, `if_id_valid` <= 0 and `if_id_instr` <= `NOP_INSTR`; the other IF/ID fields still hold.
  - `flush` (no stall): `pc_q` <= `pc_q + 4`; `if_id_valid` <= 0 and `if_id_instr` <= `NOP_INSTR`.
  - Otherwise (normal fetch):
    - IF/ID captures {`pc_q`, `imem_instr`, `pc_q + 4`} with `if_id_valid` <= 1.
    - `pc_q` <= `pc_q + 4`.
- FAULT: all inputs except `rst` are ignored. `pc_q` holds, `if_id_valid` = 0, `fetch_fault` = 1. Only `rst` exits FAULT.
- `fetch_count` increments by 1 on every normal-fetch edge. It wraps from 2^32-1 to 0.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC + 4` = 0, and `if_id_pc_plus4` wraps the same way.
- A redirect target of 0 is legal. The PC is never checked against memory size; out-of-range addresses are the memory's concern.

## Timing
- `imem_addr` is combinational from `pc_q`; no other output has a combinational path from any input.
- Normal fetch: the word at `pc_q` in cycle N appears on IF/ID outputs in cycle N+1.
- Reset: `rst` high at edge E0 gives BOOT. The first fetch (at `RESET_PC`) is captured at edge E0+2, so `if_id_valid` first goes high after E0+2.
- Redirect: asserted in cycle N gives `imem_addr` = target in N+1 and the target instruction on IF/ID in N+2. That is one bubble, in N+1.
- Stall: held outputs are bit-identical for every stalled cycle. Fetching resumes from the held `pc_q`.
- `rst` mid-operation, in any state: full reset values at the next edge, and any in-flight redirect is discarded.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_e` {BOOT, RUN, FAULT}
  - `INSTR_BYTES` = 4
  - default `NOP_INSTR` constant
  - `if_id_t` struct {valid, pc, instr, pc_plus4}
- One sub-module, `if_id_register`:
  - holds an `if_id_t`
  - inputs: load enable, squash
  - reset behaviour as specified above
- PC register, FSM and counter live in `instruction_fetch`.

## Test plan
- Reset, then 4 free-running cycles with memory returning `addr ^ 32'hA5A5_0000` -> `if_id_pc` = 0, 4, 8; instructions match; `fetch_count` = 3; `if_id_valid` is 0 during BOOT.
- Stall held 3 cycles at `pc_q` = 0x10 -> IF/ID frozen, `imem_addr` stays 0x10, `fetch_count` unchanged; after release the next capture has `if_id_pc` = 0x10.
- Redirect to 0x100 while `stall` = 1 -> next cycle `imem_addr` = 0x100 and `if_id_valid` = 0; the cycle after, `if_id_pc` = 0x100.
- Redirect to 0x102 -> `fetch_fault` = 1 and `if_id_valid` = 0; later stalls and redirects are ignored; `rst` restores `pc_q` = `RESET_PC`.
- `RESET_PC` = 32'hFFFF_FFF8, free run -> `if_id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; `if_id_pc_plus4` = 0 when `if_id_pc` = FFFF_FFFC.
- `flush` alone at `pc_q` = 0x20 -> `if_id_valid` = 0 and `if_id_instr` = `NOP_INSTR`; `pc_q` = 0x24; `fetch_count` unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/if_id_register.sv
//------------------------------------------------------------------------------
// Module   : if_id_register
// Brief    : IF/ID pipeline register with load and squash controls.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   squash,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t r_q;

    // Squash only clears valid/instr; pc fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q.valid    <= 1'b0;
            r_q.pc       <= 32'd0;
            r_q.instr    <= NOP_INSTR;
            r_q.pc_plus4 <= 32'd0;
        end else if (load) begin
            r_q <= d;
        end else if (squash) begin
            r_q.valid <= 1'b0;
            r_q.instr <= NOP_INSTR;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// Module   : instruction_fetch
// Brief    : PC, fetch FSM, IF/ID capture and fetch counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic [31:0]  r_count;
    logic         w_load, w_squash, w_count_inc;
    logic [31:0]  w_pc_plus4;
    if_id_t       w_if_id_d, w_if_id_q;

    assign w_pc_plus4 = r_pc + INSTR_BYTES;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_count_inc) r_count <= r_count + 32'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_squash     = 1'b0;
        w_count_inc  = 1'b0;
        case (r_state)
            BOOT: w_state_next = RUN;
            RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    w_state_next = FAULT;
                    w_squash     = 1'b1;
                end else if (redirect_valid) begin
                    w_pc_next = redirect_pc;
                    w_squash  = 1'b1;
                end else if (stall) begin
                    w_squash = flush;
                end else if (flush) begin
                    w_pc_next = w_pc_plus4;
                    w_squash  = 1'b1;
                end else begin
                    w_pc_next   = w_pc_plus4;
                    w_load      = 1'b1;
                    w_count_inc = 1'b1;
                end
            end
            FAULT: w_state_next = FAULT;
            default: w_state_next = BOOT;
        endcase
    end

    always_comb begin
        w_if_id_d          = '0;
        w_if_id_d.valid    = 1'b1;
        w_if_id_d.pc       = r_pc;
        w_if_id_d.instr    = imem_instr;
        w_if_id_d.pc_plus4 = w_pc_plus4;
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .squash (w_squash),
        .d      (w_if_id_d),
        .q      (w_if_id_q)
    );

    assign imem_addr      = r_pc;
    assign if_id_valid    = w_if_id_q.valid;
    assign if_id_pc       = w_if_id_q.pc;
    assign if_id_instr    = w_if_id_q.instr;
    assign if_id_pc_plus4 = w_if_id_q.pc_plus4;
    // The fault flag is the FAULT state itself, so it is sticky until reset.
    assign fetch_fault    = (r_state == FAULT);
    assign fetch_count    = r_count;

endmodule

`default_nettype wire
